// File: rtl/serial_encoder.sv
// Multi-hot to serial binary-index encoder: emits one index beat per set bit of an accepted vector.
// Build option: define SERIAL_ENCODER_MSB_FIRST_EN to emit indices highest-first instead of lowest-first.
module serial_encoder #(
  parameter int NUM_WIRE = 5
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic [NUM_WIRE-1:0]         d_i,
  input  logic                        d_valid_i,
  output logic                        d_ready_o,
  output logic [$clog2(NUM_WIRE)-1:0] a_o,
  output logic                        a_valid_o,
  input  logic                        a_ready_i,
  output logic                        a_last_o
);

  localparam int AW = $clog2(NUM_WIRE);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [NUM_WIRE-1:0] pending_reg, pending_next;
  logic [AW-1:0]       a_o_reg, a_o_next;
  logic                a_valid_reg, a_valid_next;
  logic                a_last_reg, a_last_next;
  logic [NUM_WIRE-1:0] clr_mask;
  logic                in_hs, out_hs;

  // Index of the next bit to serialise from a pending vector.
  function automatic logic [AW-1:0] pick_idx(input logic [NUM_WIRE-1:0] v);
    pick_idx = '0;
`ifdef SERIAL_ENCODER_MSB_FIRST_EN
    for (int i = 0; i < NUM_WIRE; i++)
      if (v[i]) pick_idx = AW'(i);
`else
    for (int i = NUM_WIRE - 1; i >= 0; i--)
      if (v[i]) pick_idx = AW'(i);
`endif
  endfunction

  function automatic logic is_onehot(input logic [NUM_WIRE-1:0] v);
    is_onehot = (v != '0) &&
                ((v & (v - {{(NUM_WIRE-1){1'b0}}, 1'b1})) == '0);
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_WIRE; gi++) begin : g_clr
      assign clr_mask[gi] = (a_o_reg == AW'(gi));
    end
  endgenerate

  assign in_hs  = d_valid_i && (state_reg == IDLE);
  assign out_hs = a_valid_reg && a_ready_i;

  // Outputs are precomputed from the next pending value so they leave the block straight from flops.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    if (state_reg == IDLE) begin
      if (in_hs && (d_i != '0)) begin
        pending_next = d_i;
        state_next   = BUSY;
      end
    end else if (out_hs) begin
      pending_next = pending_reg & ~clr_mask;
      if (a_last_reg) begin
        pending_next = '0;
        state_next   = IDLE;
      end
    end
    a_valid_next = (state_next == BUSY);
    a_o_next     = a_valid_next ? pick_idx(pending_next) : '0;
    a_last_next  = a_valid_next && is_onehot(pending_next);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      a_o_reg     <= '0;
      a_valid_reg <= 1'b0;
      a_last_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      a_o_reg     <= a_o_next;
      a_valid_reg <= a_valid_next;
      a_last_reg  <= a_last_next;
    end
  end

  assign d_ready_o = (state_reg == IDLE);
  assign a_o       = a_o_reg;
  assign a_valid_o = a_valid_reg;
  assign a_last_o  = a_last_reg;

endmodule

// File: tb/tb_serial_encoder.sv
// Scoreboard bench for serial_encoder: directed scenarios plus randomized vectors vs. a queue model.
module tb_serial_encoder;

  localparam int N  = 5;
  localparam int AW = $clog2(N);

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic [N-1:0]  d_i;
  logic          d_valid_i;
  logic          d_ready_o;
  logic [AW-1:0] a_o;
  logic          a_valid_o;
  logic          a_ready_i;
  logic          a_last_o;

  serial_encoder #(.NUM_WIRE(N)) dut (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .d_i      (d_i),
    .d_valid_i(d_valid_i),
    .d_ready_o(d_ready_o),
    .a_o      (a_o),
    .a_valid_o(a_valid_o),
    .a_ready_i(a_ready_i),
    .a_last_o (a_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int idx;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_beats  = 0;
  int    n_vec    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one beat per set bit, ordered by index; the final beat carries last.
  task automatic push_vector(input logic [N-1:0] d);
    int idx[$];
    for (int i = 0; i < N; i++)
      if (d[i]) idx.push_back(i);
`ifdef SERIAL_ENCODER_MSB_FIRST_EN
    idx.reverse();
`endif
    for (int k = 0; k < idx.size(); k++) begin
      beat_t b;
      b.idx  = idx[k];
      b.last = (k == idx.size() - 1);
      exp_q.push_back(b);
    end
    n_vec++;
    $display("vector %b accepted, %0d beats expected", d, idx.size());
  endtask

  // Monitor: compare DUT outputs against the queue head every falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (arst_i) begin
        chk("rst_a_valid", a_valid_o, 0);
        chk("rst_d_ready", d_ready_o, 1);
        chk("rst_a_o", a_o, 0);
        chk("rst_a_last", a_last_o, 0);
      end else begin
        chk("d_ready", d_ready_o, (exp_q.size() == 0) ? 1 : 0);
        chk("a_valid", a_valid_o, (exp_q.size() != 0) ? 1 : 0);
        if (exp_q.size() != 0) begin
          chk("a_o", a_o, exp_q[0].idx);
          chk("a_last", a_last_o, exp_q[0].last);
          if (a_ready_i && a_valid_o) begin
            $display("beat a_o=%0d last=%0b", a_o, a_last_o);
            void'(exp_q.pop_front());
            n_beats++;
          end
        end else begin
          chk("idle_a_o", a_o, 0);
          chk("idle_a_last", a_last_o, 0);
        end
      end
    end
  end

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic step(input logic [N-1:0] d, input logic v, input logic r);
    logic acc;
    d_i = d; d_valid_i = v; a_ready_i = r;
    @(negedge clk_i);
    acc = v && d_ready_o && !arst_i;
    @(posedge clk_i);
    if (acc && d != '0) push_vector(d);
    else if (acc) $display("zero vector accepted, no beats expected");
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      step('0, 1'b0, 1'b1);
      c++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
    step('0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [N-1:0] d;
    int cyc;
    arst_i = 1'b1; d_i = '0; d_valid_i = 1'b0; a_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 arst_i = 1'b0;

    // Ascending burst under continuous ready; first accept right after reset release.
    step(5'b10110, 1'b1, 1'b1);
    drain(20);

    // Stalled first beat must hold steady.
    step(5'b10110, 1'b1, 1'b0);
    repeat (4) step('0, 1'b0, 1'b0);
    drain(20);

    // Zero vector is consumed silently.
    step(5'b00000, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);

    // All bits set; also offer a vector while busy, which must be ignored.
    step(5'b11111, 1'b1, 1'b1);
    step(5'b01000, 1'b1, 1'b1);
    drain(20);

    // Reset mid-vector discards remaining beats.
    step(5'b10110, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    arst_i = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_a_valid", a_valid_o, 0);
    chk("async_rst_d_ready", d_ready_o, 1);
    step('0, 1'b0, 1'b1);
    arst_i = 1'b0;
    step(5'b00001, 1'b1, 1'b1);
    drain(20);

    // Randomized traffic.
    cyc = 0;
    while (n_vec < 60 && cyc < 5000) begin
      d = N'($urandom);
      if ($urandom_range(0, 7) == 0) d = '0;
      step(d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      cyc++;
    end
    drain(100);
    chk("random_vectors_accepted", (n_vec >= 60) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
